// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the async PS/2 lines, validates 11-bit frames and
// decodes scan-code set 2 make/break sequences into held levels for Space, Left and Right.
module ps2_key_decoder #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_space,
    output logic       key_left,
    output logic       key_right,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int TCNT_W      = $clog2(TIMEOUT_CYC);
    localparam int FCNT_W      = $clog2(FILTER_LEN + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    localparam logic [1:0] D_BASE = 2'd0;
    localparam logic [1:0] D_E0   = 2'd1;
    localparam logic [1:0] D_F0   = 2'd2;
    localparam logic [1:0] D_E0F0 = 2'd3;

    logic              clk_meta, clk_sync, data_meta, data_sync;
    logic              clk_filt;
    logic [FCNT_W-1:0] filt_cnt;
    logic              filt_flip, fall;

    logic [0:0]        state;
    logic [3:0]        bit_cnt;
    logic [8:0]        shift_reg;
    logic [TCNT_W-1:0] tcnt;
    logic              timeout_hit;
    logic [1:0]        dstate;

    // NOTE: idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            {clk_meta, clk_sync, data_meta, data_sync} <= 4'b1111;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // The filtered clock flips only after FILTER_LEN consecutive samples disagreeing with it.
    assign filt_flip = (clk_sync != clk_filt) && (filt_cnt == FCNT_W'(FILTER_LEN - 1));
    assign fall      = filt_flip && clk_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_RECV) && !fall && (tcnt == TCNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (fall || timeout_hit || state == S_IDLE) tcnt <= '0;
            else                                        tcnt <= tcnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        if (!data_sync) begin
                            state   <= S_RECV;
                            bit_cnt <= 4'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (fall) begin
                        if (bit_cnt == 4'd10) begin
                            // shift_reg holds data[7:0] and parity in bit 8; data_sync is the stop bit.
                            state   <= S_IDLE;
                            bit_cnt <= '0;
                            if (data_sync && ^shift_reg) begin
                                byte_valid <= 1'b1;
                                byte_data  <= shift_reg[7:0];
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            shift_reg <= {data_sync, shift_reg[8:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state     <= S_IDLE;
                        bit_cnt   <= '0;
                        frame_err <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dstate    <= D_BASE;
            key_space <= 1'b0;
            key_left  <= 1'b0;
            key_right <= 1'b0;
        end else if (timeout_hit) begin
            dstate <= D_BASE;
        end else if (byte_valid) begin
            case (dstate)
                D_BASE: begin
                    case (byte_data)
                        8'hE0:   dstate <= D_E0;
                        8'hF0:   dstate <= D_F0;
                        8'h29:   key_space <= 1'b1;
                        default: ;
                    endcase
                end
                D_E0: begin
                    dstate <= D_BASE;
                    case (byte_data)
                        8'hF0:   dstate <= D_E0F0;
                        8'h6B:   key_left  <= 1'b1;
                        8'h74:   key_right <= 1'b1;
                        default: ;
                    endcase
                end
                D_F0: begin
                    dstate <= D_BASE;
                    if (byte_data == 8'h29) key_space <= 1'b0;
                end
                default: begin
                    dstate <= D_BASE;
                    if (byte_data == 8'h6B) key_left  <= 1'b0;
                    if (byte_data == 8'h74) key_right <= 1'b0;
                end
            endcase
        end
    end

endmodule
